// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronised UART receiver with mid-bit sampling, framing check and valid/ready output
module uart_rx_sampler #(
  parameter int WIDTH = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, nxt;
  logic s1, rx_s, hit, good, load;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] sr;
  // two-flop synchroniser, idles high so reset never fakes a start bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, rx_s} <= 2'b11;
    else {s1, rx_s} <= {rx_in, s1};
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // timer target per state, stop-bit load decision and next state
  always_comb begin
    hit = timer == (state == START ? HALF : FULL);
    good = state == STOP && hit && rx_s;
    load = good && (!data_valid || data_ready);
    nxt = state;
    case (state)
      IDLE:  nxt = rx_s ? IDLE : START;
      START: nxt = hit ? (rx_s ? IDLE : DATA) : START;
      DATA:  nxt = hit && idx == IW'(WIDTH - 1) ? STOP : DATA;
      STOP:  nxt = hit ? (rx_s ? IDLE : BRK) : STOP;
      BRK:   nxt = rx_s ? IDLE : BRK;
      default: nxt = IDLE;
    endcase
  end
  // bit timer restarts on every state entry; shift register fills LSB-first via right shift
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      timer <= '0;
      idx <= '0;
      sr <= '0;
    end else begin
      timer <= (nxt != state || hit || state == IDLE || state == BRK) ? '0 : timer + 1'b1;
      idx <= state == START && hit ? '0 : state == DATA && hit ? idx + 1'b1 : idx;
      sr <= state == DATA && hit ? {rx_s, sr[WIDTH-1:1]} : sr;
    end
  // output word, handshake and one-cycle error pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data_out <= load ? sr : data_out;
      data_valid <= load ? 1'b1 : data_valid && data_ready ? 1'b0 : data_valid;
      frame_err <= state == STOP && hit && !rx_s;
      overrun <= good && !load;
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for the UART receive sampler
module tb_uart_rx_sampler;
  localparam int C = 16;
  logic clk = 0, reset = 0, rx_in = 1, data_ready = 1;
  logic [7:0] data_out;
  logic data_valid, frame_err, overrun;
  int total = 0, bad = 0, ferr_cnt = 0, ovr_cnt = 0, f0, o0;
  logic [7:0] q[$];
  logic pv = 0, pa = 0;
  logic [7:0] po = 0;
  uart_rx_sampler #(.WIDTH(8), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (C) tick();
    end
    rx_in = stop;
    repeat (C) tick();
  endtask
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err || overrun) chk("excl", {31'b0, frame_err & overrun}, 0);
    if (pv && !pa && data_valid) chk("hold", data_out, po);
    if (data_valid && data_ready) begin
      if (q.size() == 0) chk("spurious", 0, 1);
      else chk("word", data_out, q.pop_front());
    end
    pv = data_valid;
    pa = data_valid & data_ready;
    po = data_out;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1;
    repeat (4) tick();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1);
      begin
        repeat (154) tick();
        chk("a5_pre", data_valid, 0);
        tick();
        chk("a5_valid", data_valid, 1);
        chk("a5_data", data_out, 8'hA5);
      end
    join
    repeat (4) tick();
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_ovr", ovr_cnt - o0, 0);
    rx_in = 0;
    repeat (5) tick();
    rx_in = 1;
    repeat (20) tick();
    chk("gl_valid", data_valid, 0);
    chk("gl_ferr", ferr_cnt - f0, 0);
    chk("gl_idle", int'(dut.state), 0);
    q.push_back(8'h3C);
    send_frame(8'h3C, 1);
    repeat (4) tick();
    f0 = ferr_cnt;
    send_frame(8'h81, 0);
    repeat (100 * C) tick();
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_valid", data_valid, 0);
    rx_in = 1;
    repeat (C) tick();
    q.push_back(8'h55);
    send_frame(8'h55, 1);
    repeat (4) tick();
    chk("brk_total", ferr_cnt - f0, 1);
    data_ready = 0;
    o0 = ovr_cnt;
    q.push_back(8'h11);
    send_frame(8'h11, 1);
    send_frame(8'h22, 1);
    chk("ov_data", data_out, 8'h11);
    chk("ov_valid", data_valid, 1);
    chk("ov_cnt", ovr_cnt - o0, 1);
    data_ready = 1;
    tick();
    chk("ov_fall", data_valid, 0);
    data_ready = 0;
    o0 = ovr_cnt;
    q.push_back(8'h11);
    send_frame(8'h11, 1);
    q.push_back(8'h22);
    fork
      send_frame(8'h22, 1);
      begin
        repeat (154) tick();
        data_ready = 1;
        tick();
        data_ready = 0;
      end
    join
    chk("sw_data", data_out, 8'h22);
    chk("sw_valid", data_valid, 1);
    chk("sw_ovr", ovr_cnt - o0, 0);
    data_ready = 1;
    tick();
    chk("sw_fall", data_valid, 0);
    data_ready = 0;
    send_frame(8'h66, 1);
    chk("rs_pend", data_valid, 1);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    fork
      send_frame(8'h0F, 1);
      begin
        repeat (5 * C + C / 2) tick();
        #3 reset = 0;
        #1;
        chk("rs_data", data_out, 0);
        chk("rs_valid", data_valid, 0);
        chk("rs_ferr", frame_err, 0);
        chk("rs_ovr", overrun, 0);
      end
    join
    tick();
    reset = 1;
    data_ready = 1;
    repeat (C) tick();
    q.push_back(8'hF0);
    send_frame(8'hF0, 1);
    repeat (5) tick();
    chk("rs_after", data_valid, 0);
    chk("rs_nferr", ferr_cnt - f0, 0);
    chk("rs_novr", ovr_cnt - o0, 0);
    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
